// File: rtl/act_buf_pkg.sv
// act_buf_pkg: shared constants and helpers for the rotating activation buffer.
//   ERR_*     : bit positions inside the sticky err vector
//   next_bank : ring increment that wraps at an arbitrary (non power-of-two) count
package act_buf_pkg;

  localparam int ERR_W             = 4;
  localparam int ERR_COMMIT_FULL   = 0;
  localparam int ERR_RELEASE_EMPTY = 1;
  localparam int ERR_WR_DROP       = 2;
  localparam int ERR_RD_DROP       = 3;

  // Advance a bank index by one, wrapping from n-1 back to 0.
  function automatic int unsigned next_bank(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/act_buf_bank.sv
// act_buf_bank: one DEPTH x DATA_W storage bank, 1 write port + 1 read port.
//   clock        : clock
//   we/waddr/wdata/wbe : byte-enabled write (wbe[i] covers byte i)
//   re/raddr     : read request, data lands in rdata one edge later
//   rdata        : registered read data (holds when re is low)
// Contents are not reset.
module act_buf_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/activation_buffer_ring.sv
// activation_buffer_ring: N-bank rotating activation buffer with commit/release
// handshakes between a producer (writer) and a consumer (reader).
//   clock, reset            : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_be : byte-enabled write into the current write bank
//   wr_commit               : hand the current write bank to the reader
//   wr_ready, wr_bank       : write bank free / its index
//   rd_en/rd_addr           : read from the current read bank (2-cycle latency)
//   rd_data, rd_data_valid  : read result; rd_data holds between valid pulses
//   rd_release              : free the current read bank
//   rd_avail, rd_bank       : a committed bank is readable / its index
//   occupancy               : committed, unreleased bank count
//   err, err_clear          : sticky error flags (set wins over clear)
module activation_buffer_ring
  import act_buf_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8192,
  parameter int NUM_BANKS = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
  localparam int OCC_W  = $clog2(NUM_BANKS + 1),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              wr_commit,
  output logic              wr_ready,
  output logic [BANK_W-1:0] wr_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic [BANK_W-1:0] rd_bank,
  output logic [OCC_W-1:0]  occupancy,
  output logic [ERR_W-1:0]  err,
  input  logic              err_clear
);

  // vld_pipe[0]: request registered, [1]: bank read done, [2]: output valid
  localparam int STAGES = 2;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
  } rd_req_t;

  logic [BANK_W-1:0] wr_idx, rd_idx;
  logic [OCC_W-1:0]  occ;
  logic              wr_ok, rd_ok;
  logic              do_commit, do_release, rd_acc;
  logic [ERR_W-1:0]  err_set;

  logic [STAGES:0]   vld_pipe;
  rd_req_t           req_q;
  logic [BANK_W-1:0] bank_s1;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_q;

  // Legality is judged on pre-edge occupancy only, so a same-cycle release
  // never makes a commit legal when full (and vice versa when empty).
  assign wr_ok      = (occ != OCC_W'(NUM_BANKS));
  assign rd_ok      = (occ != '0);
  assign do_commit  = wr_commit  && wr_ok;
  assign do_release = rd_release && rd_ok;
  assign rd_acc     = rd_en      && rd_ok;

  assign wr_ready  = wr_ok;
  assign rd_avail  = rd_ok;
  assign wr_bank   = wr_idx;
  assign rd_bank   = rd_idx;
  assign occupancy = occ;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (do_commit)  wr_idx <= BANK_W'(next_bank(32'(wr_idx), NUM_BANKS));
      if (do_release) rd_idx <= BANK_W'(next_bank(32'(rd_idx), NUM_BANKS));
      case ({do_commit, do_release})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    err_set                    = '0;
    err_set[ERR_COMMIT_FULL]   = wr_commit  && !wr_ok;
    err_set[ERR_RELEASE_EMPTY] = rd_release && !rd_ok;
    err_set[ERR_WR_DROP]       = wr_en      && !wr_ok;
    err_set[ERR_RD_DROP]       = rd_en      && !rd_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) err <= '0;
    else       err <= (err_clear ? '0 : err) | err_set;
  end

  // Read pipeline: the bank index travels with the request so a release
  // after issue cannot redirect data already in flight.
  always_ff @(posedge clock) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], rd_acc};
  end

  always_ff @(posedge clock) begin
    if (rd_acc) req_q <= '{bank: rd_idx, addr: rd_addr};
    bank_s1 <= req_q.bank;
  end

  always_ff @(posedge clock) begin
    if (reset)            rd_data <= '0;
    else if (vld_pipe[1]) rd_data <= bank_q[bank_s1];
  end

  assign rd_data_valid = vld_pipe[STAGES];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    act_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clock (clock),
      .we    (wr_en && wr_ok && (wr_idx == BANK_W'(i))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .wbe   (wr_be),
      .re    (vld_pipe[0] && (req_q.bank == BANK_W'(i))),
      .raddr (req_q.addr),
      .rdata (bank_q[i])
    );
  end

endmodule

// File: tb/tb_activation_buffer_ring.sv
// Bench for activation_buffer_ring (3 banks, 16 words): directed vectors with
// literal expectations, plus a per-cycle comparison against a queue-based model.
module tb_activation_buffer_ring;

  localparam int DW = 64, DEP = 16, NB = 3, AW = 4, BW = 2, OW = 2, BEW = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 0, wr_commit = 0, rd_en = 0, rd_release = 0, err_clear = 0;
  logic [AW-1:0]  wr_addr = '0, rd_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [BEW-1:0] wr_be = '0;
  logic           wr_ready, rd_data_valid, rd_avail;
  logic [BW-1:0]  wr_bank, rd_bank;
  logic [DW-1:0]  rd_data;
  logic [OW-1:0]  occupancy;
  logic [3:0]     err;

  always #5 clock = ~clock;

  activation_buffer_ring #(.DATA_W(DW), .DEPTH(DEP), .NUM_BANKS(NB)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_release(rd_release), .rd_avail(rd_avail), .rd_bank(rd_bank),
    .occupancy(occupancy), .err(err), .err_clear(err_clear)
  );

  int total = 0, bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [63:0] d; bit kn; } pend_t;
  logic [63:0] mmem [NB][DEP];
  bit          mkn  [NB][DEP];
  pend_t       pq[$];
  int          cyc = 0, m_wr = 0, m_rd = 0, m_occ = 0;
  logic [3:0]  m_err = '0;
  logic [63:0] m_data = '0;
  bit          m_vld = 0, m_kn = 1;

  initial for (int b = 0; b < NB; b++) for (int a = 0; a < DEP; a++) mkn[b][a] = 0;

  always @(posedge clock) begin
    bit wok, rok;
    logic [3:0] s;
    cyc++;
    if (reset) begin
      m_wr = 0; m_rd = 0; m_occ = 0; m_err = '0;
      m_data = '0; m_vld = 0; m_kn = 1;
      pq.delete();
    end else begin
      wok = (m_occ < NB);
      rok = (m_occ > 0);
      s = '0;
      m_vld = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_vld = 1; m_data = pq[0].d; m_kn = pq[0].kn;
        void'(pq.pop_front());
      end
      if (rd_en) begin
        if (rok) pq.push_back('{cyc + 2, mmem[m_rd][rd_addr], mkn[m_rd][rd_addr]});
        else s[3] = 1;
      end
      if (wr_en) begin
        if (wok) begin
          for (int b = 0; b < BEW; b++)
            if (wr_be[b]) mmem[m_wr][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
          if (wr_be == '1) mkn[m_wr][wr_addr] = 1;
        end else s[2] = 1;
      end
      if (wr_commit) begin
        if (wok) begin m_wr = (m_wr + 1) % NB; m_occ++; end
        else s[0] = 1;
      end
      if (rd_release) begin
        if (rok) begin m_rd = (m_rd + 1) % NB; m_occ--; end
        else s[1] = 1;
      end
      m_err = (err_clear ? 4'b0 : m_err) | s;
    end
  end

  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      chk("m.valid", rd_data_valid, m_vld);
      if (m_kn) chk("m.rd_data", rd_data, m_data);
      chk("m.occupancy", occupancy, m_occ);
      chk("m.wr_ready", wr_ready, m_occ < NB);
      chk("m.rd_avail", rd_avail, m_occ > 0);
      chk("m.wr_bank", wr_bank, m_wr);
      chk("m.rd_bank", rd_bank, m_rd);
      chk("m.err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; err_clear = 0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be; tick();
  endtask
  task automatic commit();  wr_commit = 1;  tick(); endtask
  task automatic release_(); rd_release = 1; tick(); endtask
  task automatic rd_expect(input string nm, input logic [AW-1:0] a, input logic [63:0] exp);
    rd_en = 1; rd_addr = a; tick();
    @(negedge clock);
    @(negedge clock); chk({nm, ".early"}, rd_data_valid, 1'b0);
    @(negedge clock); chk({nm, ".valid"}, rd_data_valid, 1'b1);
                      chk({nm, ".data"},  rd_data, exp);
    @(negedge clock); chk({nm, ".pulse"}, rd_data_valid, 1'b0);
  endtask

  initial begin
    int seq [5];
    logic [63:0] x, y;
    seq = '{0, 1, 2, 0, 1};

    repeat (3) tick();
    reset = 0;
    cmp_en = 1;
    @(negedge clock);
    chk("rst.occ", occupancy, 0);
    chk("rst.wr_ready", wr_ready, 1);
    chk("rst.rd_avail", rd_avail, 0);
    chk("rst.err", err, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.valid", rd_data_valid, 0);
    chk("rst.banks", {wr_bank, rd_bank}, 0);

    // basic flow
    wr(5, 64'hA5A5_A5A5_A5A5_0001, 8'hFF);
    commit();
    @(negedge clock);
    chk("basic.occ", occupancy, 1);
    chk("basic.wr_bank", wr_bank, 1);
    rd_expect("basic", 5, 64'hA5A5_A5A5_A5A5_0001);

    // byte enables (bank 1)
    wr(2, 64'h1111_1111_1111_1111, 8'hFF);
    wr(2, 64'h2222_2222_2222_2222, 8'h0F);
    commit();
    release_();
    @(negedge clock);
    chk("be.rd_bank", rd_bank, 1);
    rd_expect("be", 2, 64'h1111_1111_2222_2222);
    release_();

    // full / empty
    for (int k = 0; k < 3; k++) begin
      wr(0, 64'hC0DE_0000 + 64'(k), 8'hFF);
      commit();
    end
    @(negedge clock);
    chk("full.occ", occupancy, 3);
    chk("full.wr_ready", wr_ready, 0);
    commit();
    wr(1, 64'hDEAD, 8'hFF);
    @(negedge clock);
    chk("full.occ2", occupancy, 3);
    chk("full.err", err, 4'b0101);
    err_clear = 1; tick();
    @(negedge clock);
    chk("clr.err", err, 0);
    for (int k = 0; k < 3; k++) begin
      rd_expect("drain", 0, 64'hC0DE_0000 + 64'(k));
      release_();
    end
    @(negedge clock);
    chk("empty.rd_avail", rd_avail, 0);
    release_();
    rd_en = 1; rd_addr = 0; tick();
    @(negedge clock);
    chk("empty.err", err, 4'b1010);
    @(negedge clock); @(negedge clock);
    chk("empty.novalid", rd_data_valid, 0);
    err_clear = 1; tick();

    // wrap with 3 banks
    reset = 1; tick(); reset = 0;
    @(negedge clock);
    chk("wrap.start", {wr_bank, rd_bank}, 0);
    for (int k = 0; k < 4; k++) begin
      commit();
      @(negedge clock);
      chk("wrap.wr_bank", wr_bank, seq[k+1]);
      chk("wrap.rd_bank_hold", rd_bank, seq[k]);
      release_();
      @(negedge clock);
      chk("wrap.rd_bank", rd_bank, seq[k+1]);
    end

    // simultaneous commit + release, read in flight across the release
    x = 64'h0BAD_F00D_0000_0001;
    y = 64'h0000_0002_0BAD_F00D;
    wr(3, x, 8'hFF);
    commit();
    wr(3, y, 8'hFF);
    rd_en = 1; rd_addr = 3; tick();
    wr_commit = 1; rd_release = 1; tick();
    @(negedge clock);
    chk("sim.occ", occupancy, 1);
    chk("sim.wr_bank", wr_bank, 0);
    chk("sim.rd_bank", rd_bank, 2);
    @(negedge clock);
    chk("sim.valid", rd_data_valid, 1);
    chk("sim.old_data", rd_data, x);
    rd_expect("sim.new", 3, y);

    // reset mid-read
    commit(); commit(); commit();
    @(negedge clock);
    chk("mid.err_pre", err, 4'b0001);
    rd_en = 1; rd_addr = 3; tick();
    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("mid.valid", rd_data_valid, 0);
      chk("mid.rd_data", rd_data, 0);
      chk("mid.occ", occupancy, 0);
      chk("mid.err", err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/activation_buffer_ring.md
# activation_buffer_ring

Parametrised N-bank rotating activation buffer, successor to the fixed 2 × 8K × 64 ping-pong activation buffer. The producer (DMA / previous layer writeback) fills one bank at a time and commits it. The consumer (PE array feeder) reads committed banks in order and releases them. Explicit commit/release handshakes replace the blind swap pulse, so a bank is never read before it is filled or overwritten before it is consumed; byte-enable writes and sticky error flags are added.

## Interface
Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- DEPTH, 8192, words per bank.
- NUM_BANKS, 2, bank count; must be ≥ 2, and need not be a power of two.
- Derived: ADDR_W = $clog2(DEPTH), BANK_W = max(1, $clog2(NUM_BANKS)), OCC_W = $clog2(NUM_BANKS+1), BE_W = DATA_W/8.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  word address within the current write bank
- wr_data  in  DATA_W  write data
- wr_be  in  BE_W  byte enables; bit i covers byte i
- wr_commit  in  1  pulse: current write bank is full, hand it to the reader
- wr_ready  out  1  current write bank is free; writes and commits are accepted
- wr_bank  out  BANK_W  index of the current write bank
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  word address within the current read bank
- rd_data  out  DATA_W  read data
- rd_data_valid  out  1  rd_data carries a new word this cycle
- rd_release  in  1  pulse: current read bank is consumed, free it
- rd_avail  out  1  at least one committed bank is available to read
- rd_bank  out  BANK_W  index of the current read bank
- occupancy  out  OCC_W  number of committed, unreleased banks
- err  out  4  sticky errors: [0] commit while full, [1] release while empty, [2] write dropped, [3] read dropped
- err_clear  in  1  clears err

## Operation
- **State:** wr_idx, rd_idx, occ.
  - wr_ready = (occ < NUM_BANKS).
  - rd_avail = (occ > 0).
  - wr_bank = wr_idx; rd_bank = rd_idx; occupancy = occ.
- **Write:** wr_en && wr_ready writes the bytes selected by wr_be into bank[wr_idx][wr_addr]. wr_en && !wr_ready is dropped and sets err[2].
- **Read:** rd_en && rd_avail reads bank[rd_idx][rd_addr]. rd_en && !rd_avail is dropped, sets err[3], and produces no rd_data_valid.
- **Commit:**
  - wr_commit && wr_ready: wr_idx advances, wrapping from NUM_BANKS-1 to 0, and occ increments.
  - wr_commit while occ == NUM_BANKS is ignored and sets err[0].
- **Release:**
  - rd_release && rd_avail: rd_idx advances with the same wrap rule, and occ decrements.
  - rd_release while occ == 0 is ignored and sets err[1].
- **Simultaneous commit and release:** both are evaluated against pre-edge occ. If both are legal, both indices advance and occ is unchanged. When occ == NUM_BANKS, commit is illegal even if a release occurs in the same cycle. Likewise, when occ == 0, release is illegal even if a commit occurs in the same cycle.
- **Same-cycle write/read and pointer updates:** a write or read in the same cycle as a commit or release uses the pre-edge bank index.
- **Bank separation:** reads and writes never target the same bank, because rd_idx == wr_idx only when occ is 0 (reads blocked) or NUM_BANKS (writes blocked). No read-during-write hazard exists.
- **Error flags:** err bits are set-dominant over err_clear in the same cycle.
- **Memory contents:** not reset.

## Timing
- **Read latency is 2 cycles**, identical to the predecessor: request at edge N, bank-register at edge N+1, output register at edge N+2. rd_data and rd_data_valid are updated at N+2.
- **Pipelining:** back-to-back reads give one word per cycle.
- **rd_data hold:** rd_data holds its last value when rd_data_valid is low.
- **Pipeline bank select:** the bank index is carried down the pipeline with the request, so a release issued at N+1 does not corrupt in-flight data.
- **Write visibility:** a write is visible to a read issued at least 1 cycle after the commit edge.
- **Reset values:** wr_idx = 0, rd_idx = 0, occ = 0, wr_ready = 1, rd_avail = 0, wr_bank = 0, rd_bank = 0, occupancy = 0, rd_data = 0, rd_data_valid = 0, err = 0.
- **Reset mid-operation:** in-flight reads are discarded (no valid pulse) and all banks become free.
- **Output timing:** wr_ready, rd_avail, wr_bank, rd_bank and occupancy are registered-state decodes with no combinational path from inputs.

## Structure
- **Package act_buf_pkg:** ERR_COMMIT_FULL = 0, ERR_RELEASE_EMPTY = 1, ERR_WR_DROP = 2, ERR_RD_DROP = 3, plus a next_bank(idx, n) wrap function.
- **Sub-module act_buf_bank:** one 1W1R DEPTH × DATA_W array with byte-enable write and a registered read. Instantiate NUM_BANKS copies in a generate loop.
- **Top level:** pointer/occupancy control, the pipelined bank-select mux, and the error logic live in the top.

## Test plan
- **Basic flow (defaults):** write 0xA5A5…0001 at addr 5 in bank 0, commit, read addr 5 → rd_data = 0xA5A5…0001 exactly 2 cycles after rd_en, with rd_data_valid high for 1 cycle, occupancy = 1, wr_bank = 1.
- **Byte enables:** write 0x1111…11 with wr_be = 0xFF, then 0x2222…22 with wr_be = 0x0F, commit, read → rd_data = 0x11111111_22222222.
- **Full / empty (NUM_BANKS = 3):** 3 commits → occupancy = 3, wr_ready = 0. A 4th commit sets err[0] and occupancy stays 3. A write while full sets err[2]. 3 releases → rd_avail = 0. A 4th release sets err[1].
- **Wrap with non-power-of-2 count (NUM_BANKS = 3):** 4 commit/release pairs → wr_bank and rd_bank follow the sequence 0, 1, 2, 0, 1.
- **Simultaneous events:** with occ = 1, commit and release in the same cycle → occupancy stays 1 and both indices advance. A read issued the cycle before the release returns the old bank's data.
- **Reset mid-read:** rd_en at N, reset at N+1 → no rd_data_valid, rd_data = 0, occupancy = 0, err = 0.
